// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: serializes fetch (F) and load/store (D) 32-bit accesses onto the 8-bit pin bus, LSB first.
// Define IO_BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed D-over-F priority.
module io_bus_arbiter #(
  parameter int         TURN_CYCLES = 1,
  parameter logic [7:0] TURN_MARK   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  input  logic [7:0]  data_input,
  output logic [7:0]  address_out,
  output logic [7:0]  data_output,
  output logic        bus_active,
  output logic        bus_we
);
  localparam int TW = TURN_CYCLES > 1 ? $clog2(TURN_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, ADDR, TURN, RDATA, DONE} state_t;
  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic [31:0]   f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic          pick;
`ifdef IO_BUS_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  // last_q = 1 means D was granted most recently
  assign pick   = f_req && d_req ? !last_q : d_req;
  assign last_d = state_q == IDLE && (f_req || d_req) ? pick : last_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b0;
    else last_q <= last_d;
`else
  assign pick = d_req;
`endif
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: if (f_req || d_req) begin
        state_d = ADDR;
        cnt_d   = 2'd0;
        gnt_d   = pick;
        we_d    = pick && d_we;
        addr_d  = pick ? d_addr : f_addr;
        wdata_d = pick ? d_wdata : 32'd0;
      end
      ADDR: begin
        cnt_d  = cnt_q + 2'd1;
        tcnt_d = '0;
        if (cnt_q == 2'd3) state_d = we_q ? DONE : TURN;
      end
      TURN: begin
        tcnt_d = tcnt_q + 1'b1;
        if (tcnt_q == TW'(TURN_CYCLES - 1)) begin
          state_d = RDATA;
          cnt_d   = 2'd0;
        end
      end
      RDATA: begin
        rbuf_d[8*cnt_q +: 8] = data_input;
        cnt_d = cnt_q + 2'd1;
        // the last byte is folded in here so rdata is valid together with ack
        if (cnt_q == 2'd3) begin
          state_d = DONE;
          if (gnt_q) d_rdata_d = rbuf_d;
          else f_rdata_d = rbuf_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      tcnt_q    <= '0;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rbuf_q    <= 32'd0;
      f_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  assign bus_active  = state_q != IDLE;
  assign bus_we      = bus_active && we_q;
  assign address_out = state_q == ADDR ? addr_q[8*cnt_q +: 8] : state_q == TURN ? TURN_MARK : 8'd0;
  assign data_output = state_q == ADDR && we_q ? wdata_q[8*cnt_q +: 8] : 8'd0;
  assign f_ack       = state_q == DONE && !gnt_q;
  assign d_ack       = state_q == DONE && gnt_q;
  assign f_rdata     = f_rdata_q;
  assign d_rdata     = d_rdata_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: cycle-position reference model plus directed scenarios on two instances (TURN_CYCLES 1 and 3).
module tb_io_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic f_req[2], d_req[2], d_we[2];
  logic [31:0] f_addr[2], d_addr[2], d_wdata[2];
  logic [7:0] din[2];
  logic f_ack[2], d_ack[2], act[2], bwe[2];
  logic [31:0] f_rdata[2], d_rdata[2];
  logic [7:0] aout[2], dout[2];
  int n_cmp = 0, n_bad = 0;
  bit run = 0, force_en = 0;
  logic [7:0] force_b = 8'h00;
  int pos[2];
  bit m_gd[2], m_we[2], m_last[2];
  logic [31:0] m_addr[2], m_wd[2], m_rbuf[2], m_fr[2], m_dr[2];
`ifdef IO_BUS_ARB_ROUND_ROBIN_EN
  localparam bit FIRST_D = 1'b0;
`else
  localparam bit FIRST_D = 1'b1;
`endif

  always #5 clk = ~clk;

  io_bus_arbiter #(.TURN_CYCLES(1)) u_t1 (
    .clk(clk), .rst(rst), .f_req(f_req[0]), .f_addr(f_addr[0]), .f_ack(f_ack[0]), .f_rdata(f_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_ack(d_ack[0]),
    .d_rdata(d_rdata[0]), .data_input(din[0]), .address_out(aout[0]), .data_output(dout[0]),
    .bus_active(act[0]), .bus_we(bwe[0]));
  io_bus_arbiter #(.TURN_CYCLES(3)) u_t3 (
    .clk(clk), .rst(rst), .f_req(f_req[1]), .f_addr(f_addr[1]), .f_ack(f_ack[1]), .f_rdata(f_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_ack(d_ack[1]),
    .d_rdata(d_rdata[1]), .data_input(din[1]), .address_out(aout[1]), .data_output(dout[1]),
    .bus_active(act[1]), .bus_we(bwe[1]));

  function automatic int tc(int i);
    return i == 0 ? 1 : 3;
  endfunction
  function automatic int tlen(int i);
    return m_we[i] ? 5 : 9 + tc(i);
  endfunction
  function automatic bit pick_d(int i);
`ifdef IO_BUS_ARB_ROUND_ROBIN_EN
    return (f_req[i] && d_req[i]) ? !m_last[i] : d_req[i];
`else
    return d_req[i];
`endif
  endfunction
  function automatic logic [7:0] e_aout(int i);
    int p;
    p = pos[i];
    if (p >= 1 && p <= 4) return m_addr[i][8*(p-1) +: 8];
    return (p != 0 && !m_we[i] && p <= 4 + tc(i)) ? 8'hFF : 8'h00;
  endfunction
  function automatic logic [7:0] e_dout(int i);
    int p;
    p = pos[i];
    return (p >= 1 && p <= 4 && m_we[i]) ? m_wd[i][8*(p-1) +: 8] : 8'h00;
  endfunction
  function automatic bit e_ack(int i, bit want_d);
    return pos[i] != 0 && pos[i] == tlen(i) && m_gd[i] == want_d;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, want %h at %0t", nm, i, a, e, $time);
    end
  endtask

  task automatic wait_ack(input int i, input int start, input int max, output int n, output bit gd);
    n = -1;
    gd = 0;
    for (int c = 0; c < max; c++) begin
      @(posedge clk); #1;
      if (f_ack[i] || d_ack[i]) begin
        n = start + c;
        gd = d_ack[i];
        break;
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    din[0] = force_en ? force_b : 8'($urandom);
    din[1] = 8'($urandom);
  end

  // transaction-level model: pos counts cycles into the current transaction, 0 when idle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        pos[i] <= 0;
        m_fr[i] <= 32'd0;
        m_dr[i] <= 32'd0;
        m_last[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pos[i] == 0) begin
          if (f_req[i] || d_req[i]) begin
            pos[i] <= 1;
            m_gd[i] <= pick_d(i);
            m_last[i] <= pick_d(i);
            m_we[i] <= pick_d(i) && d_we[i];
            m_addr[i] <= pick_d(i) ? d_addr[i] : f_addr[i];
            m_wd[i] <= d_wdata[i];
          end
        end else begin
          if (!m_we[i] && pos[i] >= 5 + tc(i) && pos[i] <= 8 + tc(i)) begin
            m_rbuf[i][8*(pos[i]-5-tc(i)) +: 8] <= din[i];
            if (pos[i] == 8 + tc(i)) begin
              if (m_gd[i]) m_dr[i] <= {din[i], m_rbuf[i][23:0]};
              else m_fr[i] <= {din[i], m_rbuf[i][23:0]};
            end
          end
          pos[i] <= pos[i] == tlen(i) ? 0 : pos[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        chk("address_out", i, 32'(aout[i]), 32'(e_aout(i)));
        chk("data_output", i, 32'(dout[i]), 32'(e_dout(i)));
        chk("bus_active", i, 32'(act[i]), 32'(pos[i] != 0));
        chk("bus_we", i, 32'(bwe[i]), 32'(pos[i] != 0 && m_we[i]));
        chk("f_ack", i, 32'(f_ack[i]), 32'(e_ack(i, 1'b0)));
        chk("d_ack", i, 32'(d_ack[i]), 32'(e_ack(i, 1'b1)));
        chk("f_rdata", i, f_rdata[i], m_fr[i]);
        chk("d_rdata", i, d_rdata[i], m_dr[i]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n, n2;
    bit gd;
    for (int i = 0; i < 2; i++) begin
      f_req[i] = 0; d_req[i] = 0; d_we[i] = 0;
      f_addr[i] = 0; d_addr[i] = 0; d_wdata[i] = 0; din[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    run = 1;
    @(posedge clk); #1;
    chk("reset_f_rdata", 0, f_rdata[0], 32'd0);
    chk("reset_d_rdata", 0, d_rdata[0], 32'd0);
    chk("reset_bus_active", 0, 32'(act[0]), 32'd0);
    chk("reset_address_out", 0, 32'(aout[0]), 32'd0);
    f_addr[0] = 32'h40;
    f_req[0] = 1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      force_en = c >= 6 && c <= 9;
      force_b = c == 6 ? 8'h24 : c == 7 ? 8'h08 : c == 8 ? 8'h00 : 8'h20;
      if (c <= 4) chk("fetch_addr_byte", 0, 32'(aout[0]), c == 1 ? 32'h40 : 32'h00);
      if (c == 5) chk("fetch_turn_mark", 0, 32'(aout[0]), 32'hFF);
      if (c == 10) begin
        chk("fetch_ack", 0, 32'(f_ack[0]), 32'd1);
        chk("fetch_rdata", 0, f_rdata[0], 32'h2000_0824);
      end
    end
    @(posedge clk); #1;
    f_req[0] = 0;
    d_addr[0] = 32'h0000_1234;
    d_wdata[0] = 32'hCAFE_BABE;
    d_we[0] = 1;
    d_req[0] = 1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c <= 4) begin
        chk("store_addr_byte", 0, 32'(aout[0]), c == 1 ? 32'h34 : c == 2 ? 32'h12 : 32'h00);
        chk("store_data_byte", 0, 32'(dout[0]), c == 1 ? 32'hBE : c == 2 ? 32'hBA : c == 3 ? 32'hFE : 32'hCA);
        chk("store_bus_we", 0, 32'(bwe[0]), 32'd1);
      end else begin
        chk("store_ack", 0, 32'(d_ack[0]), 32'd1);
        chk("store_keeps_d_rdata", 0, d_rdata[0], 32'd0);
      end
    end
    @(posedge clk); #1;
    d_req[0] = 0;
    @(posedge clk); #1;
    d_we[0] = 0; d_addr[0] = 32'h0000_0200; d_req[0] = 1;
    f_addr[0] = 32'h0000_0300; f_req[0] = 1;
    wait_ack(0, 1, 40, n, gd);
    chk("simul_first_cycle", 0, 32'(n), 32'd10);
    chk("simul_first_is_d", 0, 32'(gd), 32'(FIRST_D));
    @(posedge clk); #1;
    if (gd) d_req[0] = 0;
    else f_req[0] = 0;
    wait_ack(0, 12, 40, n, gd);
    chk("simul_second_cycle", 0, 32'(n), 32'd21);
    chk("simul_second_is_d", 0, 32'(gd), 32'(!FIRST_D));
    @(posedge clk); #1;
    f_req[0] = 0; d_req[0] = 0;
    @(posedge clk); #1;
    d_we[0] = 0; d_addr[0] = 32'h0000_0500; d_req[0] = 1;
    repeat (8) @(posedge clk);
    #1 rst = 1;
    d_req[0] = 0;
    #1;
    chk("rst_bus_active", 0, 32'(act[0]), 32'd0);
    chk("rst_d_ack", 0, 32'(d_ack[0]), 32'd0);
    chk("rst_address_out", 0, 32'(aout[0]), 32'd0);
    chk("rst_d_rdata", 0, d_rdata[0], 32'd0);
    chk("rst_f_rdata", 0, f_rdata[0], 32'd0);
    @(posedge clk); #1;
    rst = 0;
    f_addr[0] = 32'h0000_0080; f_req[0] = 1;
    wait_ack(0, 1, 40, n, gd);
    chk("post_rst_fetch_cycle", 0, 32'(n), 32'd10);
    chk("post_rst_fetch_is_d", 0, 32'(gd), 32'd0);
    @(posedge clk); #1;
    f_req[0] = 0;
    @(posedge clk); #1;
    d_we[0] = 1; d_addr[0] = 32'h0000_0600; d_wdata[0] = 32'h1122_3344; d_req[0] = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_req[0] = 0; d_addr[0] = 32'hDEAD_BEEF; d_wdata[0] = 32'h0;
    wait_ack(0, 3, 20, n, gd);
    chk("dropped_req_ack_cycle", 0, 32'(n), 32'd5);
    chk("dropped_req_ack_is_d", 0, 32'(gd), 32'd1);
    @(posedge clk); #1;
    d_we[1] = 0; d_addr[1] = 32'h0000_0700; d_req[1] = 1;
    wait_ack(1, 1, 40, n, gd);
    chk("t3_first_ack_cycle", 1, 32'(n), 32'd12);
    wait_ack(1, 13, 40, n2, gd);
    chk("t3_second_ack_cycle", 1, 32'(n2), 32'd25);
    chk("t3_ack_spacing", 1, 32'(n2 - n), 32'd13);
    @(posedge clk); #1;
    d_req[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
